// File: rtl/axil_slave_regfile.sv
// AXI4-Lite responder for a small bank of 32-bit registers. Register contents and
// per-register write pulses are exported to user fabric logic.
module axil_slave_regfile #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]               reg_wr_pulse
);

  localparam int unsigned AW        = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW        = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW        = DW / 8;
  localparam int unsigned IDX_W     = $clog2(NUM_REGS);
  localparam int unsigned MAP_BYTES = NUM_REGS * 4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_RESP} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic          aw_hs_c, w_hs_c, ar_hs_c, commit_c;
  logic [AW-1:0] wr_addr_c;
  logic [DW-1:0] wr_data_c;
  logic [SW-1:0] wr_strb_c;
  logic          unused_prot;

  function automatic logic is_mapped(input logic [AW-1:0] a);
    return 32'(a) < MAP_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [AW-1:0] a);
    return a[2 +: IDX_W];
  endfunction

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign aw_hs_c = S_AXI_AWVALID & awready_q;
  assign w_hs_c  = S_AXI_WVALID  & wready_q;
  assign ar_hs_c = S_AXI_ARVALID & arready_q;

  // Whichever half arrived first was latched; the other comes straight off the bus.
  assign wr_addr_c = (wstate_q == W_HAVE_ADDR) ? awaddr_q : S_AXI_AWADDR;
  assign wr_data_c = (wstate_q == W_HAVE_DATA) ? wdata_q  : S_AXI_WDATA;
  assign wr_strb_c = (wstate_q == W_HAVE_DATA) ? wstrb_q  : S_AXI_WSTRB;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    commit_c  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (aw_hs_c && w_hs_c) begin
          commit_c = 1'b1;
        end else if (aw_hs_c) begin
          awaddr_d  = S_AXI_AWADDR;
          awready_d = 1'b0;
          wstate_d  = W_HAVE_ADDR;
        end else if (w_hs_c) begin
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
          wready_d = 1'b0;
          wstate_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: if (w_hs_c) commit_c = 1'b1;
      W_HAVE_DATA: if (aw_hs_c) commit_c = 1'b1;
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    if (commit_c) begin
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = is_mapped(wr_addr_c) ? RESP_OKAY : RESP_SLVERR;
      wstate_d  = W_RESP;
    end
  end

  // Byte-merge of the committed write; unmapped writes leave the bank untouched.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (commit_c && is_mapped(wr_addr_c)) begin
      for (int unsigned b = 0; b < SW; b++) begin
        if (wr_strb_c[b]) regs_d[reg_idx(wr_addr_c)][8*b +: 8] = wr_data_c[8*b +: 8];
      end
      wr_pulse_d[reg_idx(wr_addr_c)] = 1'b1;
    end
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs_c) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rstate_d  = R_RESP;
          if (is_mapped(S_AXI_ARADDR)) begin
            rdata_d = regs_q[reg_idx(S_AXI_ARADDR)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_wr_pulse  = wr_pulse_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign reg_out[DW*k +: DW] = regs_q[k];
  end

endmodule
